// File: rtl/matrix_mem_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of the single-port
// main matrix memory (16 slots x 256 bits). One transaction is in flight at a
// time. The grant, address and write data are captured in the IDLE cycle that
// accepts a request. Every output comes straight from a register.
//
// Handshake (req/ack): a requester raises reqN with weN/addrN/wdataN stable
// and holds all of them until it sees ackN high for one cycle. The arbiter
// samples requests only in IDLE, so a requester that keeps reqN high after
// ackN, with new fields, is accepted in the IDLE cycle that follows RESP.
// errN is meaningful only while ackN is high. rdata is meaningful while the
// ack of a read is high and holds until the next read completes.
module matrix_mem_arbiter #(
   parameter logic [3:0] MEM_SEL = 4'h0,
   parameter int         DATA_W  = 256,
   parameter int         ADDR_W  = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_DataIn,
   output logic              mem_nRead,
   output logic              mem_nWrite,
   input  logic [DATA_W-1:0] mem_DataOut,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t state;

   // Transaction context latched at grant time.
   logic gnt_id;    // 0 = requester 0, 1 = requester 1
   logic lat_we;    // 1 = write
   logic lat_err;   // module-select mismatch
   // Id favoured on the next contention; holds the id not served last.
   logic rr_ptr;

   // Combinational winner selection and field mux for the IDLE cycle.
   logic              any_req;
   logic              pick;
   logic              pick_we;
   logic [ADDR_W-1:0] pick_addr;
   logic [DATA_W-1:0] pick_wdata;
   logic              pick_sel_ok;

   // Choose the winner among the current requests and mux its fields.
   always_comb begin
      any_req     = req0 | req1;
      pick        = 1'b0;
      if (req0 && req1) begin
         pick = rr_ptr;
      end else begin
         pick = req1;
      end
      pick_we     = pick ? we1    : we0;
      pick_addr   = pick ? addr1  : addr0;
      pick_wdata  = pick ? wdata1 : wdata0;
      pick_sel_ok = (pick_addr[ADDR_W-1:ADDR_W-4] == MEM_SEL);
   end

   // Sequencer FSM with registered strobes, acks and read data.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         gnt_id      <= 1'b0;
         lat_we      <= 1'b0;
         lat_err     <= 1'b0;
         rr_ptr      <= 1'b0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         err0        <= 1'b0;
         err1        <= 1'b0;
         rdata       <= '0;
         busy        <= 1'b0;
         mem_address <= '0;
         mem_DataIn  <= '0;
         mem_nRead   <= 1'b1;
         mem_nWrite  <= 1'b1;
      end else begin
         // Pulses and strobes default to their idle levels every cycle.
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         mem_nRead  <= 1'b1;
         mem_nWrite <= 1'b1;
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt_id  <= pick;
                  lat_we  <= pick_we;
                  lat_err <= ~pick_sel_ok;
                  busy    <= 1'b1;
                  if (!pick_sel_ok) begin
                     // Foreign module select: answer at once, memory untouched.
                     state <= RESP;
                     ack0  <= ~pick;
                     ack1  <= pick;
                     err0  <= ~pick;
                     err1  <= pick;
                  end else begin
                     state       <= ISSUE;
                     mem_address <= pick_addr;
                     if (pick_we) begin
                        mem_nWrite <= 1'b0;
                        mem_DataIn <= pick_wdata;
                     end else begin
                        mem_nRead <= 1'b0;
                     end
                  end
               end
            end
            ISSUE: begin
               if (lat_we) begin
                  state <= RESP;
                  ack0  <= ~gnt_id;
                  ack1  <= gnt_id;
               end else begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               // Memory output is valid the cycle after the read strobe.
               rdata <= mem_DataOut;
               state <= RESP;
               ack0  <= ~gnt_id;
               ack1  <= gnt_id;
            end
            RESP: begin
               rr_ptr <= ~gnt_id;
               state  <= IDLE;
               busy   <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_matrix_mem_arbiter.sv
// Self-checking bench for matrix_mem_arbiter: directed steps followed by a
// randomized phase, all checked against a transaction-level model of the
// arbitration, latency and memory contents.
module tb_matrix_mem_arbiter;

   localparam logic [3:0] MEM_SEL = 4'h0;

   logic         Clk = 1'b0;
   logic         Reset = 1'b1;
   logic         req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [15:0]  addr0 = '0, addr1 = '0;
   logic [255:0] wdata0 = '0, wdata1 = '0;
   logic         ack0, ack1, err0, err1, busy, mem_nRead, mem_nWrite;
   logic [255:0] rdata, mem_DataIn, mem_DataOut;
   logic [15:0]  mem_address;
   logic [1:0]   dbg_state;

   matrix_mem_arbiter #(.MEM_SEL(MEM_SEL), .DATA_W(256), .ADDR_W(16)) dut (
      .Clk(Clk), .Reset(Reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
      .rdata(rdata), .busy(busy),
      .mem_address(mem_address), .mem_DataIn(mem_DataIn),
      .mem_nRead(mem_nRead), .mem_nWrite(mem_nWrite),
      .mem_DataOut(mem_DataOut), .dbg_state(dbg_state)
   );

   // Clock and cycle counter.
   always #5 Clk = ~Clk;
   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   // Memory environment: 16 slots, registered read data.
   logic [255:0] env_mem [16];
   logic [255:0] ref_mem [16];
   logic         load_mem = 1'b1;
   always @(posedge Clk) begin
      if (load_mem) begin
         for (int i = 0; i < 16; i++) env_mem[i] <= ref_mem[i];
      end else if (!mem_nWrite) begin
         env_mem[mem_address[3:0]] <= mem_DataIn;
      end
      if (!mem_nRead) mem_DataOut <= env_mem[mem_address[3:0]];
   end

   // Reference model state.
   int           last_served = -1;   // -1: no grant since reset
   logic [255:0] last_rdata = '0;
   logic         t_we   [2];
   logic [15:0]  t_addr [2];
   logic [255:0] t_wd   [2];

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Winner under the round-robin rule: alone wins; on contention the one
   // not served last, with requester 0 first after reset.
   function automatic int model_pick(input bit p0, input bit p1);
      if (p0 && p1) return (last_served == 0) ? 1 : 0;
      return p1 ? 1 : 0;
   endfunction

   task automatic drive(input int i, input logic r);
      if (i == 0) begin
         req0 = r; we0 = t_we[0]; addr0 = t_addr[0]; wdata0 = t_wd[0];
      end else begin
         req1 = r; we1 = t_we[1]; addr1 = t_addr[1]; wdata1 = t_wd[1];
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_acks"}, {ack1, ack0, err1, err0}, 0);
      check({tag, "_strobes"}, {mem_nRead, mem_nWrite}, 2'b11);
      check({tag, "_addr"}, mem_address, 0);
      check({tag, "_datain"}, mem_DataIn, 0);
      check({tag, "_rdata"}, rdata, 0);
   endtask

   // Raise the given requests and follow them to completion. With n_total
   // larger than the number of requesters, requests stay high after ack
   // until n_total acks are seen; chg then loads new fields after each ack.
   task automatic serve(input bit r0, input bit r1, input int n_total, input bit chg);
      bit pend [2];
      bit keep, e_err;
      int done, sample_cyc, nrd, nwr, budget, id, lat_exp;
      keep = (n_total > (int'(r0) + int'(r1)));
      @(negedge Clk);
      pend[0] = r0; pend[1] = r1;
      drive(0, r0); drive(1, r1);
      sample_cyc = cyc; nrd = 0; nwr = 0; done = 0; budget = 0;
      while (done < n_total) begin
         @(negedge Clk);
         budget++;
         id = model_pick(pend[0], pend[1]);
         if (!mem_nRead && !mem_nWrite) check("strobe_overlap", 1, 0);
         if (!mem_nRead || !mem_nWrite) begin
            check("mem_address", mem_address, t_addr[id]);
            if (!mem_nWrite) check("mem_datain", mem_DataIn, t_wd[id]);
            if (!mem_nRead) nrd++;
            if (!mem_nWrite) nwr++;
         end
         if (ack0 || ack1) begin
            e_err = (t_addr[id][15:12] != MEM_SEL);
            lat_exp = e_err ? 1 : (t_we[id] ? 2 : 3);
            check("ack_id", {ack1, ack0}, (id == 1) ? 2'b10 : 2'b01);
            check("err", {err1, err0}, e_err ? ((id == 1) ? 2'b10 : 2'b01) : 2'b00);
            check("latency", cyc - sample_cyc, lat_exp);
            check("nread_pulses", nrd, (!e_err && !t_we[id]) ? 1 : 0);
            check("nwrite_pulses", nwr, (!e_err && t_we[id]) ? 1 : 0);
            check("busy_at_ack", busy, 1);
            if (!e_err && t_we[id]) ref_mem[t_addr[id][3:0]] = t_wd[id];
            if (!e_err && !t_we[id]) last_rdata = ref_mem[t_addr[id][3:0]];
            check("rdata", rdata, last_rdata);
            last_served = id;
            done++;
            budget = 0; nrd = 0; nwr = 0;
            sample_cyc = cyc + 1;
            if (!keep) begin
               pend[id] = 0;
               drive(id, 1'b0);
            end else if (chg && done < n_total) begin
               t_addr[id] = t_addr[id] + 16'd1;
               t_wd[id] = rnd256();
               drive(id, 1'b1);
            end
         end
         if (budget > 8) begin
            check("ack_timeout", budget, 0);
            break;
         end
      end
      drive(0, 1'b0); drive(1, 1'b0);
      @(negedge Clk);
      check("busy_after", busy, 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ref_mem[i] = rnd256();
      ref_mem[0] = 256'h0004_000c_0004_0022_0007_0006_000b_0009_0009_0002_0008_000d_0002_000f_0010_0003;
      for (int i = 0; i < 2; i++) begin t_we[i] = 0; t_addr[i] = '0; t_wd[i] = '0; end
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0; load_mem = 1'b0;
      check_reset_outputs("reset");

      // Read of slot 0 by requester 0.
      t_we[0] = 0; t_addr[0] = 16'h0000;
      serve(1, 0, 1, 0);
      check("slot0_value", rdata, 256'h0004_000c_0004_0022_0007_0006_000b_0009_0009_0002_0008_000d_0002_000f_0010_0003);

      // Write all-ones to slot 2 by requester 1, then read it back by requester 0.
      t_we[1] = 1; t_addr[1] = 16'h0002; t_wd[1] = '1;
      serve(0, 1, 1, 0);
      t_we[0] = 0; t_addr[0] = 16'h0002;
      serve(1, 0, 1, 0);
      check("slot2_readback", rdata, {256{1'b1}});

      // Foreign module select.
      t_we[0] = 0; t_addr[0] = 16'h1005;
      serve(1, 0, 1, 0);

      // Reset during the capture cycle of a read.
      @(negedge Clk);
      t_we[0] = 0; t_addr[0] = 16'h0003;
      drive(0, 1'b1);
      @(negedge Clk);
      @(negedge Clk);
      check("busy_in_capture", busy, 1);
      check("no_ack_in_capture", {ack1, ack0}, 0);
      Reset = 1'b1;
      @(negedge Clk);
      check_reset_outputs("mid_reset");
      Reset = 1'b0;
      drive(0, 1'b0);
      last_served = -1;
      last_rdata = '0;

      // Contention: both reading, held for four transactions.
      t_we[0] = 0; t_addr[0] = 16'h0002;
      t_we[1] = 0; t_addr[1] = 16'h0000;
      serve(1, 1, 4, 0);

      // Back-to-back writes from requester 1 to slots 3, 4, 5.
      t_we[1] = 1; t_addr[1] = 16'h0003; t_wd[1] = rnd256();
      serve(0, 1, 3, 1);
      for (int i = 3; i <= 5; i++) check("b2b_slot", env_mem[i], ref_mem[i]);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         int who;
         who = $urandom_range(1, 3);
         for (int i = 0; i < 2; i++) begin
            t_we[i] = 1'($urandom_range(0, 1));
            t_wd[i] = rnd256();
            if ($urandom_range(0, 7) == 0)
               t_addr[i] = {4'($urandom_range(1, 15)), 8'h00, 4'($urandom_range(0, 15))};
            else
               t_addr[i] = {MEM_SEL, 8'h00, 4'($urandom_range(0, 15))};
         end
         if ($urandom_range(0, 3) == 0 && who == 3)
            serve(1, 1, 2 + $urandom_range(0, 3), 1);
         else
            serve(who[0], who[1], int'(who[0]) + int'(who[1]), 0);
      end

      for (int i = 0; i < 16; i++) check("final_mem", env_mem[i], ref_mem[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
